// File: rtl/dbf_scan_ctrl_pkg.sv
// Shared widths and state encoding for the DBF scan-line sequencer.
package dbf_scan_ctrl_pkg;
   localparam int DBF_ADDR_WD = 10;
   localparam int DBF_CNT_WD  = 12;
   localparam int DBF_LINE_WD = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_TX,
      S_GUARD,
      S_RX,
      S_NEXT,
      S_DONE
   } state_t;
endpackage

// File: rtl/dbf_phase_timer.sv
// Loadable down-counter with terminal count, shared by the TX/GUARD/RX
// phases; also reports how many cycles have elapsed since the load.
module dbf_phase_timer #(
   parameter int CNT_WD = 12
) (
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_load,
   input  logic [CNT_WD-1:0] i_val,
   output logic              o_tc,
   output logic [CNT_WD-1:0] o_idx
);
   logic [CNT_WD-1:0] r_cnt;
   logic [CNT_WD-1:0] r_idx;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
         r_idx <= '0;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
         r_idx <= r_idx + 1'b1;
      end
   end

   assign o_tc  = (r_cnt == '0);
   assign o_idx = r_idx;
endmodule

// File: rtl/dbf_scan_ctrl.sv
// Scan-line sequencer: loads one line of delay LUT, opens the TX window,
// waits a guard gap, then holds start for the receive window.
module dbf_scan_ctrl
   import dbf_scan_ctrl_pkg::*;
#(
   parameter int ADDR_WD      = DBF_ADDR_WD,
   parameter int LUT_DEPTH    = 1024,
   parameter int TX_CYCLES    = 64,
   parameter int GUARD_CYCLES = 16,
   parameter int RX_SAMPLES   = 2048,
   parameter int NUM_LINES    = 128,
   parameter int CNT_WD       = DBF_CNT_WD,
   parameter int LINE_WD      = DBF_LINE_WD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               abort,
   input  logic               lut_valid,
   output logic               lut_ready,
   output logic               tx_en,
   output logic               start,
   output logic [ADDR_WD-1:0] dbf_lut_addr,
   output logic               dbf_lut_we,
   output logic [LINE_WD-1:0] line_idx,
   output logic [CNT_WD-1:0]  rx_sample_cnt,
   output logic               busy,
   output logic               frame_done
);
   localparam logic [CNT_WD-1:0] TX_LD = CNT_WD'(TX_CYCLES - 1);
   localparam logic [CNT_WD-1:0] GD_LD =
      CNT_WD'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam logic [CNT_WD-1:0]  RX_LD     = CNT_WD'(RX_SAMPLES - 1);
   localparam logic [ADDR_WD-1:0] LAST_ADDR = ADDR_WD'(LUT_DEPTH - 1);
   localparam logic [LINE_WD-1:0] LAST_LINE = LINE_WD'(NUM_LINES - 1);

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_WD-1:0] r_addr;
   logic [LINE_WD-1:0] r_line;
   logic               r_tx;
   logic               r_start;
   logic               r_busy;
   logic               r_done;
   logic               w_we;
   logic               w_last;
   logic               w_load;
   logic [CNT_WD-1:0]  w_val;
   logic               w_tc;
   logic [CNT_WD-1:0]  w_idx;

   dbf_phase_timer #(.CNT_WD(CNT_WD)) u_timer (
      .clk    (clk),
      .i_clr  (rst_n | abort),
      .i_load (w_load),
      .i_val  (w_val),
      .o_tc   (w_tc),
      .o_idx  (w_idx)
   );

   assign w_we   = lut_valid & (r_state == S_LOAD);
   assign w_last = (r_addr == LAST_ADDR);

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_val  = '0;
      unique case (r_state)
         S_IDLE: if (frame_start) w_next = S_LOAD;
         S_LOAD: if (w_we && w_last) begin
            w_next = S_TX;
            w_load = 1'b1;
            w_val  = TX_LD;
         end
         S_TX: if (w_tc) begin
            w_load = 1'b1;
            if (GUARD_CYCLES == 0) begin
               w_next = S_RX;
               w_val  = RX_LD;
            end else begin
               w_next = S_GUARD;
               w_val  = GD_LD;
            end
         end
         S_GUARD: if (w_tc) begin
            w_next = S_RX;
            w_load = 1'b1;
            w_val  = RX_LD;
         end
         S_RX:   if (w_tc) w_next = S_NEXT;
         S_NEXT: w_next = (r_line == LAST_LINE) ? S_DONE : S_LOAD;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (abort) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_line  <= '0;
         r_tx    <= 1'b0;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_tx    <= (w_next == S_TX);
         r_start <= (w_next == S_RX);
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         if (abort) begin
            r_addr <= '0;
            r_line <= '0;
         end else begin
            if (w_we) r_addr <= w_last ? '0 : r_addr + 1'b1;
            if (r_state == S_NEXT && r_line != LAST_LINE)
               r_line <= r_line + 1'b1;
            if (r_state == S_DONE) r_line <= '0;
            if (r_state == S_IDLE && frame_start) begin
               r_addr <= '0;
               r_line <= '0;
            end
         end
      end
   end

   assign lut_ready     = (r_state == S_LOAD);
   assign dbf_lut_we    = w_we;
   assign dbf_lut_addr  = r_addr;
   assign line_idx      = r_line;
   assign rx_sample_cnt = (r_state == S_RX) ? w_idx : '0;
   assign tx_en         = r_tx;
   assign start         = r_start;
   assign busy          = r_busy;
   assign frame_done    = r_done;
endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Bench for dbf_scan_ctrl: timeline model checked every cycle, plus
// directed frames and an edge-parameter instance.
module tb_dbf_scan_ctrl;
   localparam int LD = 4;
   localparam int TX = 3;
   localparam int GD = 2;
   localparam int RX = 5;
   localparam int NL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        frame_start = 1'b0;
   logic        abort = 1'b0;
   logic        lut_valid = 1'b0;
   logic        lut_ready;
   logic        tx_en;
   logic        start;
   logic [9:0]  dbf_lut_addr;
   logic        dbf_lut_we;
   logic [6:0]  line_idx;
   logic [11:0] rx_sample_cnt;
   logic        busy;
   logic        frame_done;

   logic        b_fs = 1'b0;
   logic        b_abort = 1'b0;
   logic        b_lv = 1'b0;
   logic        b_ready;
   logic        b_tx;
   logic        b_start;
   logic [1:0]  b_addr;
   logic        b_we;
   logic [6:0]  b_line;
   logic [11:0] b_rx;
   logic        b_busy;
   logic        b_done;

   int n_pass = 0;
   int n_chk = 0;
   int cyc = 0;
   int done_cnt = 0;

   dbf_scan_ctrl #(
      .LUT_DEPTH(LD), .TX_CYCLES(TX), .GUARD_CYCLES(GD),
      .RX_SAMPLES(RX), .NUM_LINES(NL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .abort(abort), .lut_valid(lut_valid), .lut_ready(lut_ready),
      .tx_en(tx_en), .start(start), .dbf_lut_addr(dbf_lut_addr),
      .dbf_lut_we(dbf_lut_we), .line_idx(line_idx),
      .rx_sample_cnt(rx_sample_cnt), .busy(busy),
      .frame_done(frame_done)
   );

   dbf_scan_ctrl #(
      .ADDR_WD(2), .LUT_DEPTH(4), .TX_CYCLES(3), .GUARD_CYCLES(0),
      .RX_SAMPLES(5), .NUM_LINES(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_start(b_fs),
      .abort(b_abort), .lut_valid(b_lv), .lut_ready(b_ready),
      .tx_en(b_tx), .start(b_start), .dbf_lut_addr(b_addr),
      .dbf_lut_we(b_we), .line_idx(b_line),
      .rx_sample_cnt(b_rx), .busy(b_busy), .frame_done(b_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // model: phase 0 idle, 1 loading, 2 line timeline, 3 frame done
   int m_ph = 0;
   int m_beats = 0;
   int m_t = 0;
   int m_line = 0;

   always @(negedge clk) begin
      automatic int e_end = TX + GD + RX;
      automatic bit e_st;
      if (cyc >= 1) begin
         e_st = (m_ph == 2) && (m_t >= TX + GD) && (m_t < e_end);
         chk("busy", busy, m_ph != 0);
         chk("lut_ready", lut_ready, m_ph == 1);
         chk("lut_we", dbf_lut_we, (m_ph == 1) && lut_valid);
         chk("lut_addr", dbf_lut_addr, (m_ph == 1) ? m_beats : 0);
         chk("tx_en", tx_en, (m_ph == 2) && (m_t < TX));
         chk("start", start, e_st);
         chk("rx_cnt", rx_sample_cnt, e_st ? m_t - TX - GD : 0);
         chk("line_idx", line_idx, m_line);
         chk("frame_done", frame_done, m_ph == 3);
         if (frame_done) done_cnt++;
      end
      if (rst_n || abort) begin
         m_ph = 0; m_line = 0; m_beats = 0; m_t = 0;
      end else begin
         case (m_ph)
            0: if (frame_start) begin
               m_ph = 1; m_beats = 0; m_line = 0;
            end
            1: if (lut_valid) begin
               m_beats++;
               if (m_beats == LD) begin
                  m_ph = 2; m_t = 0; m_beats = 0;
               end
            end
            2: if (m_t == e_end) begin
               if (m_line == NL - 1) m_ph = 3;
               else begin
                  m_line++; m_ph = 1; m_beats = 0;
               end
            end else m_t++;
            default: begin
               m_ph = 0; m_line = 0;
            end
         endcase
      end
   end

   initial begin
      int n, d0, tx_first, st_first, done_n, rx_at12;
      int b_wr, b_tx_last, b_st_first, b_done_n, b_addr5;
      bit b_ok, hit;

      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_addr", dbf_lut_addr, 0);
      rst_n = 1'b0;
      tick();

      // edge instance: no guard, one line, LUT fills the whole address space
      b_lv = 1'b1; b_fs = 1'b1;
      tick();
      b_fs = 1'b0;
      n = 1; b_wr = 0; b_ok = 1; b_tx_last = -1; b_st_first = -1;
      b_done_n = -1; b_addr5 = -1;
      while (n < 60 && b_done_n < 0) begin
         if (b_we) begin
            if (int'(b_addr) != b_wr) b_ok = 0;
            b_wr++;
         end
         if (n == 5) b_addr5 = int'(b_addr);
         if (b_tx) b_tx_last = n;
         if (b_start && b_st_first < 0) b_st_first = n;
         if (b_done) b_done_n = n;
         tick(); n++;
      end
      chk("b_writes", b_wr, 4);
      chk("b_addr_seq", b_ok, 1);
      chk("b_addr_wrap", b_addr5, 0);
      chk("b_tx_last", b_tx_last, 7);
      chk("b_start_first", b_st_first, 8);
      chk("b_frame_done", b_done_n, 14);
      b_lv = 1'b0;

      // nominal frame
      lut_valid = 1'b1; frame_start = 1'b1; d0 = done_cnt;
      tick();
      frame_start = 1'b0;
      n = 1; tx_first = -1; st_first = -1; done_n = -1; rx_at12 = -1;
      while (n < 200 && done_n < 0) begin
         if (tx_en && tx_first < 0) tx_first = n;
         if (start && st_first < 0) st_first = n;
         if (n == 12) rx_at12 = int'(rx_sample_cnt);
         if (frame_done) done_n = n;
         else begin tick(); n++; end
      end
      chk("nom_tx_first", tx_first, 5);
      chk("nom_start_first", st_first, 10);
      chk("nom_rx_at12", rx_at12, 2);
      chk("nom_done_cycle", done_n, 31);
      tick();
      chk("nom_done_count", done_cnt - d0, 1);

      // back-pressure: lut_valid only on odd cycles of the load
      frame_start = 1'b1; lut_valid = 1'b0;
      tick();
      frame_start = 1'b0;
      n = 1; tx_first = -1;
      while (n < 40) begin
         lut_valid = n[0];
         #2;
         if (tx_en && tx_first < 0) tx_first = n;
         tick(); n++;
      end
      chk("bp_tx_first", tx_first, 8);
      lut_valid = 1'b1;
      for (int i = 0; i < 40; i++) tick();

      // abort at RX sample 2
      d0 = done_cnt;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (start && rx_sample_cnt == 2) hit = 1;
         else tick();
      end
      chk("abort_reach", hit, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_start", start, 0);
      chk("abort_busy", busy, 0);
      chk("abort_line", line_idx, 0);
      chk("abort_rx", rx_sample_cnt, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("abort_no_done", done_cnt - d0, 0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      chk("abort_clean_frame", done_cnt - d0, 1);

      // reset mid-TX together with frame_start
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
         if (tx_en) hit = 1;
         else tick();
      end
      chk("rst_reach_tx", hit, 1);
      rst_n = 1'b1; frame_start = 1'b1;
      tick();
      rst_n = 1'b0; frame_start = 1'b0;
      chk("rst_tx", tx_en, 0);
      chk("rst_busy_mid", busy, 0);
      chk("rst_line", line_idx, 0);
      tick();
      chk("rst_fs_ignored", busy, 0);

      // frame_start pulsed in GUARD (n=8) and RX (n=12)
      d0 = done_cnt;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n = 1; done_n = -1;
      while (n < 60) begin
         frame_start = (n == 8 || n == 12);
         #2;
         if (frame_done && done_n < 0) done_n = n;
         tick(); n++;
      end
      frame_start = 1'b0;
      chk("fs_busy_done_cycle", done_n, 31);
      chk("fs_busy_done_count", done_cnt - d0, 1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         rst_n       = ($urandom_range(0, 999) < 2);
         abort       = ($urandom_range(0, 999) < 4);
         frame_start = ($urandom_range(0, 999) < 40);
         lut_valid   = ($urandom_range(0, 99) < 70);
         tick();
      end
      rst_n = 1'b0; abort = 1'b0; frame_start = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
